// File: rtl/partial_engine_if.sv
// Handshake and data bus for the partial-parity encode engine: operands in, one
// registered result out per accepted input set.
interface partial_engine_if #(
   parameter int K_MAX         = 8,
   parameter int W             = 4,
   parameter int PACKET_LENGTH = 2
);
   logic                               in_valid;
   logic [K_MAX*W*W-1:0]               bitmatrix;
   logic [K_MAX*W*PACKET_LENGTH-1:0]   data;
   logic [W*K_MAX*PACKET_LENGTH-1:0]   mask;
   logic                               out_valid;
   logic [W*PACKET_LENGTH-1:0]         result;

   modport master (output in_valid, bitmatrix, data, mask, input out_valid, result);
   modport slave  (input in_valid, bitmatrix, data, mask, output out_valid, result);
endinterface

// File: rtl/partial_engine.sv
// GF(2) bit-matrix multiply, per-bit mask and cross-packet XOR tree, with a single
// output register stage; one input set per cycle, one cycle of latency.
module partial_engine #(
   parameter int K_MAX         = 8,
   parameter int W             = 4,
   parameter int PACKET_LENGTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   partial_engine_if.slave   bus
);
   localparam int PL     = PACKET_LENGTH;
   localparam int LEVELS = $clog2(K_MAX);

   // Node count at tree level l; odd leftovers are carried up unchanged.
   function automatic int cnt(input int l);
      return (K_MAX + (1 << l) - 1) >> l;
   endfunction

   function automatic int off(input int l);
      int s;
      s = 0;
      for (int j = 0; j < l; j++) s += cnt(j);
      return s;
   endfunction

   localparam int NODES = off(LEVELS + 1);

   logic [PL-1:0]   prod   [K_MAX][W];
   logic [PL-1:0]   masked [W][K_MAX];
   logic [PL-1:0]   pool   [W][NODES];
   logic [W*PL-1:0] res;

   always_comb begin
      for (int k = 0; k < K_MAX; k++) begin
         for (int r = 0; r < W; r++) begin
            prod[k][r] = '0;
            for (int c = 0; c < W; c++)
               if (bus.bitmatrix[(k*W+c)*W+r]) prod[k][r] ^= bus.data[(k*W+c)*PL +: PL];
         end
      end
   end

   // AND before any XOR so masked-off slots cannot leak unknowns into the tree.
   always_comb begin
      for (int r = 0; r < W; r++)
         for (int k = 0; k < K_MAX; k++)
            masked[r][k] = prod[k][r] & bus.mask[(r*K_MAX+k)*PL +: PL];
   end

   for (genvar r = 0; r < W; r++) begin : g_row
      for (genvar k = 0; k < K_MAX; k++) begin : g_leaf
         assign pool[r][k] = masked[r][k];
      end
      for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
         for (genvar i = 0; i < cnt(l + 1); i++) begin : g_node
            localparam int SRC = off(l) + 2*i;
            localparam int DST = off(l + 1) + i;
            if (2*i + 1 < cnt(l)) begin : g_pair
               assign pool[r][DST] = pool[r][SRC] ^ pool[r][SRC+1];
            end else begin : g_pass
               assign pool[r][DST] = pool[r][SRC];
            end
         end
      end
      assign res[r*PL +: PL] = pool[r][NODES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.result    <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) bus.result <= res;
      end
   end
endmodule

// File: tb/tb_partial_engine.sv
// Randomized and directed checks of partial_engine against a flat arithmetic model.
module tb_partial_engine;
   localparam int K   = 8;
   localparam int W   = 4;
   localparam int PL  = 2;
   localparam int BMW = K*W*W;
   localparam int DW  = K*W*PL;
   localparam int MW  = W*K*PL;
   localparam int RW  = W*PL;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   partial_engine_if #(.K_MAX(K), .W(W), .PACKET_LENGTH(PL)) bus ();
   partial_engine #(.K_MAX(K), .W(W), .PACKET_LENGTH(PL)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Straight from the definition: multiply each packet, mask, XOR into the row.
   function automatic logic [RW-1:0] model(input logic [BMW-1:0] bm, input logic [DW-1:0] d,
                                           input logic [MW-1:0] m);
      logic [RW-1:0] res;
      logic [PL-1:0] acc, p;
      res = '0;
      for (int r = 0; r < W; r++) begin
         acc = '0;
         for (int k = 0; k < K; k++) begin
            p = '0;
            for (int c = 0; c < W; c++)
               if (bm[(k*W+c)*W+r]) p ^= d[(k*W+c)*PL +: PL];
            acc ^= p & m[(r*K+k)*PL +: PL];
         end
         res[r*PL +: PL] = acc;
      end
      return res;
   endfunction

   task automatic drive(input logic v, input logic [BMW-1:0] bm, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
      @(negedge clk);
      bus.in_valid  = v;
      bus.bitmatrix = bm;
      bus.data      = d;
      bus.mask      = m;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [BMW-1:0] v1_bm, id_bm, bm;
   logic [DW-1:0]  v1_d, d, dx;
   logic [MW-1:0]  v1_m, m, m6;
   logic [RW-1:0]  exp_r;

   initial begin
      v1_bm = '0; v1_bm[31:0] = 32'hF17D_F17D;
      v1_d  = '0; v1_d[15:0]  = 16'hCBD6;
      v1_m  = 64'h000F_000F_000F_000F;
      m6    = 64'h0007_0007_0007_0007;
      id_bm = '0;
      for (int k = 0; k < K; k++)
         for (int c = 0; c < W; c++) id_bm[(k*W+c)*W+c] = 1'b1;

      bus.in_valid = 1'b0; bus.bitmatrix = '0; bus.data = '0; bus.mask = '0;
      #2;
      chk("rst_result", bus.result, 0);
      chk("rst_valid", bus.out_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reference vector, then hold
      drive(1, v1_bm, v1_d, v1_m); tick();
      chk("v1_valid", bus.out_valid, 1);
      chk("v1_result", bus.result, 8'h6F);
      chk("v1_model", bus.result, model(v1_bm, v1_d, v1_m));
      drive(0, '0, '0, '0); tick();
      chk("hold_valid", bus.out_valid, 0);
      chk("hold_result", bus.result, 8'h6F);

      // Async reset mid-cycle, then recovery
      #2 rst_n = 1'b0;
      #1;
      chk("arst_result", bus.result, 0);
      chk("arst_valid", bus.out_valid, 0);
      #1 rst_n = 1'b1;
      drive(1, v1_bm, v1_d, v1_m); tick();
      chk("post_rst_valid", bus.out_valid, 1);
      chk("post_rst_result", bus.result, 8'h6F);

      // Zero mask, zero bitmatrix
      drive(1, v1_bm, v1_d, '0); tick();
      chk("zmask_valid", bus.out_valid, 1);
      chk("zmask_result", bus.result, 0);
      d = {$urandom, $urandom};
      drive(1, '0, d, '1); tick();
      chk("zbm_result", bus.result, 0);

      // Per-bit mask on slot 1
      drive(1, v1_bm, v1_d, m6); tick();
      chk("bitmask_result", bus.result, 8'h4D);
      exp_r = model(v1_bm, v1_d, m6);
      for (int r = 0; r < W; r++)
         chk($sformatf("bitmask_row%0d", r), bus.result[r*PL +: PL], exp_r[r*PL +: PL]);

      // Identity matrices: each row is the XOR of that word across packets
      for (int n = 0; n < 100; n++) begin
         d = {$urandom, $urandom};
         exp_r = '0;
         for (int w = 0; w < W; w++)
            for (int k = 0; k < K; k++) exp_r[w*PL +: PL] ^= d[(k*W+w)*PL +: PL];
         drive(1, id_bm, d, '1); tick();
         chk("id_valid", bus.out_valid, 1);
         chk("id_result", bus.result, exp_r);
      end

      // Single enabled slot, unknown data elsewhere
      for (int n = 0; n < 10; n++) begin
         bm = {$urandom, $urandom, $urandom, $urandom};
         d  = {$urandom, $urandom};
         dx = 'x;
         dx[5*W*PL +: W*PL] = d[5*W*PL +: W*PL];
         m = '0;
         for (int r = 0; r < W; r++) m[(r*K+5)*PL +: PL] = 2'b11;
         drive(1, bm, dx, m); tick();
         chk("slot5_result", bus.result, model(bm, d, m));
         chk("slot5_nox", {63'd0, $isunknown(bus.result)}, 0);
      end

      // Fully random operands
      for (int n = 0; n < 40; n++) begin
         bm = {$urandom, $urandom, $urandom, $urandom};
         d  = {$urandom, $urandom};
         m  = {$urandom, $urandom};
         drive(1, bm, d, m); tick();
         chk("rand_result", bus.result, model(bm, d, m));
      end
      drive(0, '0, '0, '0); tick();
      chk("idle_valid", bus.out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
